// File: rtl/add_seq_pkg.sv
// Shared definitions for the sequential slice adder: slice width and the
// controller state encoding.
package add_seq_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_slice8.sv
// Combinational 8-bit adder slice with carry in and carry out. The controller
// reuses a single instance for every slice of an operation.
module add_slice8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_s,
    output logic       o_cout
);

    logic [8:0] w_full;

    // Full 9-bit sum; the top bit becomes the slice carry out.
    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
        o_s    = w_full[7:0];
        o_cout = w_full[8];
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential multi-slice adder controller. Operands are latched when start is
// accepted in IDLE, then one 8-bit slice is added per cycle through a shared
// add_slice8 instance. sum/cout are registered and change only when the
// result is complete; done pulses for exactly one cycle.
//
// Optional feature: define ADD_SEQ_SUB_EN to add the sub input. With sub=1
// latched at start, the operation is A + ~B + 1 (cin ignored) and cout=1
// means "no borrow". Without the macro the block is an adder only.
//
// Handshake: start is a request level sampled only in IDLE; it is ignored
// (not queued) while busy. done is the single-cycle completion strobe and
// sum/cout are valid from that cycle until the next completion or reset.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SLICE_W*NUM_SLICES-1:0] din_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] din_b,
    input  logic                          cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                          sub,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          cout,
    output state_t                        o_dbg_state
);

    localparam int W     = SLICE_W * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_cin;
    logic [W-1:0]     r_acc;
    logic             r_carry;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [W-1:0]       w_b_eff;
    logic               w_cin_eff;
    logic [SLICE_W-1:0] w_slice_a;
    logic [SLICE_W-1:0] w_slice_b;
    logic [SLICE_W-1:0] w_slice_s;
    logic               w_slice_cin;
    logic               w_slice_cout;
    logic [W-1:0]       w_acc_next;

    // Operand conditioning at latch time: subtraction becomes A + ~B + 1.
    always_comb begin
`ifdef ADD_SEQ_SUB_EN
        w_b_eff   = sub ? ~din_b : din_b;
        w_cin_eff = sub ? 1'b1 : cin;
`else
        w_b_eff   = din_b;
        w_cin_eff = cin;
`endif
    end

    // Select the current slice and fold its result into the accumulator.
    always_comb begin
        w_slice_a   = r_a[r_idx*SLICE_W +: SLICE_W];
        w_slice_b   = r_b[r_idx*SLICE_W +: SLICE_W];
        w_slice_cin = (r_idx == '0) ? r_cin : r_carry;
        w_acc_next  = r_acc;
        w_acc_next[r_idx*SLICE_W +: SLICE_W] = w_slice_s;
    end

    add_slice8 u_slice (
        .i_a    (w_slice_a),
        .i_b    (w_slice_b),
        .i_cin  (w_slice_cin),
        .o_s    (w_slice_s),
        .o_cout (w_slice_cout)
    );

    // Controller FSM with registered busy/done/sum/cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= din_a;
                        r_b     <= w_b_eff;
                        r_cin   <= w_cin_eff;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_slice_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign sum         = r_sum;
    assign cout        = r_cout;
    assign o_dbg_state = r_state;

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLICES, default 4, number of 8-bit slices per operation (operand width W = 8*NUM_SLICES).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port din_a  input  W  operand A.
REQ-006 SHALL have port din_b  input  W  operand B.
REQ-007 SHALL have port cin  input  1  carry into slice 0.
REQ-008 SHALL have port sub  input  1  subtract request; present only when ADD_SEQ_SUB_EN is defined.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port sum  output  W  registered result.
REQ-012 SHALL have port cout  output  1  registered carry out of the top slice.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy = (state != IDLE).
REQ-014 SHALL accept start only in IDLE; on that edge latch din_a, din_b, cin (and sub), clear slice index to 0, go to RUN.
REQ-015 SHALL ignore start in RUN and DONE; no queuing, no operand update.
REQ-016 SHALL in RUN add one 8-bit slice per cycle, slice idx = index, carry in = cin for idx 0 else registered carry of idx-1.
REQ-017 SHALL store each slice sum into an internal W-bit accumulator at bits [8*idx+7:8*idx] and the slice carry into a carry register.
REQ-018 SHALL leave RUN for DONE on the edge that completes slice NUM_SLICES-1.
REQ-019 SHALL update sum and cout only on the edge entering DONE; they hold the last result otherwise.
REQ-020 SHALL assert done exactly in the DONE cycle, i.e. first high NUM_SLICES+1 edges after the edge sampling start (5 for default), then return to IDLE.
REQ-021 SHALL allow start in the cycle after DONE (IDLE) with no bubble beyond that cycle.
REQ-022 SHALL compute sum = (A + B + cin) mod 2^W, cout = bit W of the full sum.

Reset
REQ-023 SHALL on rst=1 at a clock edge force IDLE, index 0, busy 0, done 0, sum 0, cout 0, accumulator and carry 0.
REQ-024 SHALL on rst during RUN abandon the operation: no done pulse, sum/cout = 0.
REQ-025 SHALL give rst priority over start on the same edge.

Configuration
REQ-026 SHALL, with ADD_SEQ_SUB_EN defined, expose sub; sub=1 latched at start computes A + ~B + 1 (cin ignored), cout = 1 means no borrow.
REQ-027 SHALL, without ADD_SEQ_SUB_EN, omit sub and perform addition only.

Structure
REQ-028 SHALL take state encoding (IDLE/RUN/DONE enum) and SLICE_W = 8 from shared package add_seq_pkg.
REQ-029 SHALL instantiate one combinational sub-module add_slice8 (8-bit a, b, cin -> 8-bit s, cout), shared across all slices.

Verification
REQ-030 SHALL cover: A=0x000000FF, B=0x00000001, cin=0 -> sum 0x00000100, cout 0, done 5 edges after start.
REQ-031 SHALL cover: A=0xFFFFFFFF, B=0x00000000, cin=1 -> sum 0x00000000, cout 1 (carry through all 4 slices).
REQ-032 SHALL cover: start held high throughout with operands changed mid-RUN -> exactly one done, result of first operands, second accepted only from IDLE.
REQ-033 SHALL cover: rst pulsed while index=2 -> next cycle busy 0, sum 0, no done pulse.
REQ-034 SHALL cover: back-to-back, start in the cycle after done with A=0x12345678, B=0x11111111 -> sum 0x23456789, cout 0.
REQ-035 SHALL cover (ADD_SEQ_SUB_EN): A=0x00000005, B=0x00000007, sub=1 -> sum 0xFFFFFFFE, cout 0; build without macro compiles with no sub port.
